// File: rtl/mcpu_core_icache_if.sv
// rtl/mcpu_core_icache_if.sv - fetch and fill-port signal bundle for the instruction cache
interface mcpu_core_icache_if;
  // fetch side
  logic [27:0]  f2ic_vaddr;
  logic         f2ic_valid;
  logic         ic2f_ready;
  logic [27:0]  f2ic_paddr;
  logic [127:0] ic2f_packet;
  logic         ic_inval;
  // memory fill side
  logic [27:0]  ic2mem_addr;
  logic         ic2mem_valid;
  logic         mem2ic_ready;
  logic         mem2ic_rvalid;
  logic [127:0] mem2ic_rdata;

  // cache view
  modport slave (
    input  f2ic_vaddr, f2ic_valid, ic_inval, mem2ic_ready, mem2ic_rvalid, mem2ic_rdata,
    output ic2f_ready, f2ic_paddr, ic2f_packet, ic2mem_addr, ic2mem_valid
  );

  // environment view (fetch stage plus memory)
  modport master (
    output f2ic_vaddr, f2ic_valid, ic_inval, mem2ic_ready, mem2ic_rvalid, mem2ic_rdata,
    input  ic2f_ready, f2ic_paddr, ic2f_packet, ic2mem_addr, ic2mem_valid
  );
endinterface

// File: rtl/mcpu_core_icache.sv
// rtl/mcpu_core_icache.sv - direct-mapped instruction cache with single-beat miss fill
module mcpu_core_icache #(
  parameter int SETS_LOG2 = 6
) (
  input logic clkrst_core_clk,
  input logic clkrst_core_rst,
  mcpu_core_icache_if.slave bus
);
  localparam int LINES = 1 << SETS_LOG2;
  localparam int TAG_W = 28 - SETS_LOG2;
  localparam logic [SETS_LOG2:0] CNT_LAST = (SETS_LOG2 + 1)'(LINES - 1);
  localparam logic [SETS_LOG2:0] CNT_ONE  = (SETS_LOG2 + 1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_INVAL} state_t;

  state_t             state;
  logic [LINES-1:0]   line_valid;
  logic [TAG_W-1:0]   tag_mem  [LINES];
  logic [127:0]       data_mem [LINES];
  logic               inval_pending;
  logic [SETS_LOG2:0] inval_cnt;
  logic [27:0]        miss_addr;
  logic               req_valid;

  logic [SETS_LOG2-1:0] idx;
  logic [TAG_W-1:0]     tag;
  logic                 hit;
  logic [SETS_LOG2-1:0] fill_idx;
  logic [TAG_W-1:0]     fill_tag;
  logic                 fill_we;

  // Lookup is asynchronous so a hit returns its packet in the request cycle.
  assign idx      = bus.f2ic_vaddr[SETS_LOG2-1:0];
  assign tag      = bus.f2ic_vaddr[27:SETS_LOG2];
  assign hit      = bus.f2ic_valid & line_valid[idx] & (tag_mem[idx] == tag);

  // The fill always targets the address latched at miss time, not the live vaddr.
  assign fill_idx = miss_addr[SETS_LOG2-1:0];
  assign fill_tag = miss_addr[27:SETS_LOG2];
  assign fill_we  = (state == S_WAIT) & bus.mem2ic_rvalid & ~clkrst_core_rst;

  // No paging: physical equals virtual.
  assign bus.f2ic_paddr   = bus.f2ic_vaddr;
  assign bus.ic2f_packet  = data_mem[idx];
  assign bus.ic2f_ready   = (state == S_IDLE) & (~bus.f2ic_valid | hit);
  assign bus.ic2mem_addr  = miss_addr;
  assign bus.ic2mem_valid = req_valid;

  // Control FSM: miss fill sequencing, whole-cache invalidation and valid bits.
  always_ff @(posedge clkrst_core_clk) begin
    if (clkrst_core_rst) begin
      state         <= S_IDLE;
      line_valid    <= '0;
      inval_pending <= 1'b0;
      inval_cnt     <= '0;
      miss_addr     <= '0;
      req_valid     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.ic_inval | inval_pending) begin
            // Invalidation wins over a miss in the same cycle.
            state         <= S_INVAL;
            inval_cnt     <= '0;
            inval_pending <= 1'b0;
          end else if (bus.f2ic_valid & ~hit) begin
            state     <= S_REQ;
            miss_addr <= bus.f2ic_vaddr;
            req_valid <= 1'b1;
          end
        end
        S_REQ: begin
          if (bus.ic_inval) inval_pending <= 1'b1;
          if (bus.mem2ic_ready) begin
            state     <= S_WAIT;
            req_valid <= 1'b0;
          end
        end
        S_WAIT: begin
          // An invalidate here is deferred so the in-flight fill still lands.
          if (bus.ic_inval) inval_pending <= 1'b1;
          if (bus.mem2ic_rvalid) begin
            line_valid[fill_idx] <= 1'b1;
            state                <= S_IDLE;
          end
        end
        S_INVAL: begin
          line_valid[inval_cnt[SETS_LOG2-1:0]] <= 1'b0;
          if (bus.ic_inval) begin
            inval_cnt <= '0;
          end else if (inval_cnt == CNT_LAST) begin
            state <= S_IDLE;
          end else begin
            inval_cnt <= inval_cnt + CNT_ONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Tag and data storage: written only by a completing fill, never reset.
  always_ff @(posedge clkrst_core_clk) begin
    if (fill_we) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= bus.mem2ic_rdata;
    end
  end
endmodule
